serial_subtractor8: RTL and testbench



---
 rtl/serial_subtractor8.sv | 129 ++++++++++++
 tb/tb_serial_subtractor8.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor: DIFF = A - B - BIN, LSB first, one full-subtractor cell
// reused over WIDTH cycles behind a START/BUSY/DONE handshake.

module serial_subtractor8_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor8 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_d, cell_bout;
  logic [WIDTH-1:0] d_sr_next;

  serial_subtractor8_fs u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // The shifted result including the bit being produced this cycle; on the
  // last bit this is the complete difference.
  assign d_sr_next = {cell_d, d_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          a_sr_d  = A;
          b_sr_d  = B;
          br_d    = BIN;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        d_sr_d = d_sr_next;
        br_d   = cell_bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = d_sr_next;
          borrow_d = cell_bout;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign DIFF   = diff_q;
  assign BORROW = borrow_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
endmodule

// File: tb/tb_serial_subtractor8.sv
// Randomized bench for serial_subtractor8 against a plain-arithmetic model
// of A - B - BIN with handshake timing checks.

module tb_serial_subtractor8;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST, START, BIN;
  logic [W-1:0] A, B;
  logic [W-1:0] DIFF;
  logic         BORROW, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_diff;
  logic         exp_borrow;

  serial_subtractor8 #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .BIN(BIN),
    .DIFF(DIFF), .BORROW(BORROW), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: unsigned subtraction with borrow, done in plain integers.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    exp_borrow = (r < 0);
    exp_diff   = W'(r + (1 << W));
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_done", 32'(DONE), 32'd0);
      chk("idle_busy", 32'(BUSY), 32'd0);
      chk("idle_diff", 32'(DIFF), 32'(exp_diff));
    end
  endtask

  // Starts an operation at the current cycle and returns in its DONE cycle.
  // poke >= 0 re-asserts START with A=1 during that busy cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit scramble, input int poke);
    int n;
    logic [W-1:0] hold_d;
    logic         hold_b;
    hold_d = exp_diff;
    hold_b = exp_borrow;
    A = a; B = b; BIN = bin; START = 1'b1;
    n = 0;
    while (1) begin
      step();
      n++;
      START = 1'b0;
      if (DONE === 1'b1) break;
      chk("busy", 32'(BUSY), 32'd1);
      chk("hold_diff", 32'(DIFF), 32'(hold_d));
      chk("hold_borrow", 32'(BORROW), 32'(hold_b));
      if (n >= 40) break;
      if (scramble) begin
        A = W'($urandom); B = W'($urandom); BIN = 1'($urandom);
      end
      if (n == poke) begin
        START = 1'b1; A = 8'h01;
      end
    end
    chk("latency", 32'(n), 32'(W + 1));
    model(a, b, bin);
    chk("diff", 32'(DIFF), 32'(exp_diff));
    chk("borrow", 32'(BORROW), 32'(exp_borrow));
    chk("busy_done", 32'(BUSY), 32'd0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0; BIN = 1'b0;
    exp_diff = '0; exp_borrow = 1'b0;
    step(); step();
    chk("rst_diff", 32'(DIFF), 32'd0);
    chk("rst_borrow", 32'(BORROW), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    RST = 1'b0;
    idle_check(2);

    run_op(8'h50, 8'h20, 1'b0, 1'b0, -1); chk("t1_diff", 32'(DIFF), 32'h30);
    idle_check(1);
    run_op(8'h20, 8'h50, 1'b0, 1'b0, -1); chk("t2a_diff", 32'(DIFF), 32'hD0);
    idle_check(1);
    run_op(8'h00, 8'h00, 1'b1, 1'b0, -1); chk("t2b_diff", 32'(DIFF), 32'hFF);
    idle_check(1);
    run_op(8'h80, 8'h01, 1'b1, 1'b0, -1); chk("t2c_diff", 32'(DIFF), 32'h7E);
    idle_check(1);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b1, -1); chk("t3_borrow", 32'(BORROW), 32'd0);
    idle_check(1);

    // Ignored START mid-operation: single DONE, original result
    run_op(8'h90, 8'h15, 1'b0, 1'b0, 3); chk("t4_diff", 32'(DIFF), 32'h7B);
    idle_check(12);

    // Back-to-back: second START in the first DONE cycle
    run_op(8'h33, 8'h11, 1'b0, 1'b0, -1);
    run_op(8'h10, 8'h20, 1'b1, 1'b0, -1); chk("t5_diff", 32'(DIFF), 32'hEF);
    idle_check(1);

    // Reset mid-operation aborts without DONE
    A = 8'h77; B = 8'h22; BIN = 1'b0; START = 1'b1;
    step(); START = 1'b0;
    step(); step(); step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_mid_diff", 32'(DIFF), 32'd0);
    chk("rst_mid_borrow", 32'(BORROW), 32'd0);
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    chk("rst_mid_done", 32'(DONE), 32'd0);
    exp_diff = '0; exp_borrow = 1'b0;
    idle_check(12);
    run_op(8'h05, 8'h07, 1'b0, 1'b0, -1); chk("t6_diff", 32'(DIFF), 32'hFE);
    idle_check(1);

    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 1) == 0) idle_check(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
